// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory controller: a data port (MDR <-> word RAM) and a fetch port
// (MBR <- byte ROM) run independently, each with WAIT_CYCLES extra wait states.
module mic1_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int PADDR_W     = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd,
    input  logic               wr,
    input  logic               fetch,
    input  logic [31:0]        mar,
    input  logic [31:0]        mdr_out,
    input  logic [31:0]        pc,
    output logic [31:0]        mdr_in,
    output logic               mdr_load,
    output logic [7:0]         mbr_in,
    output logic               mbr_load,
    output logic               data_busy,
    output logic               fetch_busy,
    output logic               err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_wren,
    input  logic [31:0]        mem_rdata,
    output logic [PADDR_W-1:0] prog_addr,
    input  logic [7:0]         prog_q
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT} data_state_t;
    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DONE} fetch_state_t;

    localparam logic [2:0] W = 3'(WAIT_CYCLES);

    data_state_t  d_state, d_next;
    fetch_state_t f_state, f_next;
    logic [2:0]   d_cnt, d_cnt_next, f_cnt, f_cnt_next;
    logic         d_start_rd, d_start_wr, d_err, f_start, f_err;
    logic [31:0]  mdr_hold;
    logic [7:0]   mbr_hold;

    // Upper address bits are discarded on purpose (address wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mar[31:ADDR_W], pc[31:PADDR_W]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            d_state <= IDLE;
            f_state <= F_IDLE;
            d_cnt   <= '0;
            f_cnt   <= '0;
        end else begin
            d_state <= d_next;
            f_state <= f_next;
            d_cnt   <= d_cnt_next;
            f_cnt   <= f_cnt_next;
        end
    end

    always_comb begin
        d_next     = d_state;
        d_cnt_next = d_cnt;
        d_start_rd = 1'b0;
        d_start_wr = 1'b0;
        d_err      = 1'b0;
        case (d_state)
            IDLE: begin
                if (rd && wr) begin
                    d_err = 1'b1;
                end else if (rd) begin
                    d_start_rd = 1'b1;
                    d_next     = RD_WAIT;
                    d_cnt_next = W;
                end else if (wr) begin
                    d_start_wr = 1'b1;
                    d_next     = WR_WAIT;
                    d_cnt_next = W;
                end
            end
            RD_WAIT: begin
                if (d_cnt == 3'd0) d_next = RD_DONE;
                else               d_cnt_next = d_cnt - 3'd1;
            end
            RD_DONE: d_next = IDLE;
            WR_WAIT: begin
                if (d_cnt == 3'd0) d_next = IDLE;
                else               d_cnt_next = d_cnt - 3'd1;
            end
            default: d_next = IDLE;
        endcase
        // Any strobe while the port is occupied, including its load cycle, is a protocol error.
        if (d_state != IDLE && (rd || wr)) d_err = 1'b1;
    end

    always_comb begin
        f_next     = f_state;
        f_cnt_next = f_cnt;
        f_start    = 1'b0;
        f_err      = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (fetch) begin
                    f_start    = 1'b1;
                    f_next     = F_WAIT;
                    f_cnt_next = W;
                end
            end
            F_WAIT: begin
                if (f_cnt == 3'd0) f_next = F_DONE;
                else               f_cnt_next = f_cnt - 3'd1;
            end
            F_DONE:  f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
        if (f_state != F_IDLE && fetch) f_err = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            prog_addr <= '0;
            mdr_hold  <= '0;
            mbr_hold  <= '0;
            err       <= 1'b0;
        end else begin
            if (d_start_rd || d_start_wr) mem_addr <= mar[ADDR_W-1:0];
            if (d_start_wr)               mem_wdata <= mdr_out;
            if (f_start)                  prog_addr <= pc[PADDR_W-1:0];
            if (mdr_load)                 mdr_hold  <= mem_rdata;
            if (mbr_load)                 mbr_hold  <= prog_q;
            err <= err | d_err | f_err;
        end
    end

    assign data_busy  = (d_state != IDLE);
    assign fetch_busy = (f_state != F_IDLE);
    assign mdr_load   = (d_state == RD_DONE);
    assign mbr_load   = (f_state == F_DONE);
    assign mem_wren   = (d_state == WR_WAIT) && (d_cnt == 3'd0);
    // The RAM/ROM registered output is forwarded during the load cycle, then held.
    assign mdr_in     = mdr_load ? mem_rdata : mdr_hold;
    assign mbr_in     = mbr_load ? prog_q : mbr_hold;

endmodule

// File: doc/mic1_mem_ctrl.md
MIC1_MEM_CTRL -- requirements
Module: mic1_mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, data-memory word-address width.
REQ-002 Parameter: PADDR_W, 12, program-memory byte-address width.
REQ-003 Parameter: WAIT_CYCLES, 0, extra wait states per access (0..7).
REQ-004 Port: clock  in  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: rd / wr / fetch  in  1 each  datapath memory strobes, sampled on the rising edge.
REQ-007 Port: mar  in  32  data word address from datapath.
REQ-008 Port: mdr_out  in  32  write data from datapath.
REQ-009 Port: pc  in  32  program byte address from datapath.
REQ-010 Port: mdr_in  out  32  read data to datapath MDR.
REQ-011 Port: mdr_load  out  1  one-cycle pulse, mdr_in valid.
REQ-012 Port: mbr_in  out  8  fetched byte to datapath MBR.
REQ-013 Port: mbr_load  out  1  one-cycle pulse, mbr_in valid.
REQ-014 Port: data_busy / fetch_busy  out  1 each  port busy.
REQ-015 Port: err  out  1  sticky protocol-error flag.
REQ-016 Port: mem_addr  out  ADDR_W  registered data-RAM word address (mar[ADDR_W-1:0]).
REQ-017 Port: mem_wdata  out  32  registered write data; mem_wren  out  1  RAM write enable.
REQ-018 Port: mem_rdata  in  32  synchronous RAM output, valid one edge after mem_addr.
REQ-019 Port: prog_addr  out  PADDR_W  registered program address (pc[PADDR_W-1:0]); prog_q  in  8  synchronous ROM output, one-edge latency.

Function
REQ-020 Data port FSM SHALL have states IDLE, RD_WAIT, RD_DONE, WR_WAIT; fetch port FSM SHALL have states IDLE, F_WAIT, F_DONE, independent of the data port.
REQ-021 In IDLE with rd=1, wr=0 sampled at edge of cycle k: capture mar into mem_addr, go RD_WAIT; after W=WAIT_CYCLES further cycles go RD_DONE; mdr_in SHALL be registered from mem_rdata and mdr_load high for exactly cycle k+2+W.
REQ-022 data_busy SHALL be high cycles k+1 through k+2+W for a read.
REQ-023 In IDLE with wr=1, rd=0 at cycle k: capture mar and mdr_out, go WR_WAIT; mem_wren SHALL be high for exactly cycle k+1+W; data_busy high cycles k+1..k+1+W; return IDLE.
REQ-024 mem_wren SHALL never be high outside WR_WAIT's final cycle; no load pulse for writes.
REQ-025 Fetch with fetch=1 at cycle k: capture pc into prog_addr; mbr_in registered from prog_q and mbr_load high exactly cycle k+2+W; fetch_busy high k+1..k+2+W.
REQ-026 Fetch and a data access in the same cycle SHALL both proceed concurrently with no added latency.
REQ-027 rd=1 and wr=1 in the same cycle SHALL set err and start no access.
REQ-028 rd or wr sampled while data_busy=1 SHALL be ignored and set err; fetch sampled while fetch_busy=1 likewise; a strobe in the load cycle itself counts as busy.
REQ-029 Back-to-back: a new request sampled the cycle after busy drops SHALL be accepted normally.
REQ-030 Address bits of mar above ADDR_W-1 and of pc above PADDR_W-1 SHALL be ignored (wrap-around).
REQ-031 mdr_in/mbr_in SHALL hold their last loaded value until the next load.
REQ-032 err SHALL remain set until reset.

Reset
REQ-033 reset=0 at a rising edge SHALL force both FSMs to IDLE and all outputs (mdr_in, mbr_in, mem_addr, mem_wdata, prog_addr, loads, busies, mem_wren, err) to 0.
REQ-034 Reset mid-access SHALL abort it: no subsequent load pulse, no mem_wren.
REQ-035 Strobes sampled during reset SHALL be ignored.

Verification
REQ-036 W=0, RAM[5]=0xDEADBEEF, rd, mar=5 at cycle 0 -> mem_addr=5 cycle 1, mdr_load=1 and mdr_in=0xDEADBEEF cycle 2 only.
REQ-037 W=0, wr, mar=0x403, mdr_out=0x12345678 -> mem_addr=0x003, mem_wren=1 cycle 1 only; subsequent read returns 0x12345678.
REQ-038 W=2, fetch, pc=0x1001, ROM[1]=0xA7 while rd mar=2 same cycle -> mbr_in=0xA7 and mdr_load both pulse cycle 4; busies high cycles 1-4.
REQ-039 rd=wr=1 cycle 0 -> err=1 from cycle 1, no mem_wren, no mdr_load; second rd at cycle 1 of an active read -> ignored, err=1.
REQ-040 Reset asserted cycle 1 of a W=0 read -> cycle 2 mdr_load=0, all outputs 0; read after release completes normally.
